// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg -- shared definitions for the data-memory responder.
//   dm_state_t    : responder FSM states (CLEAR, IDLE, WAIT, RESP)
//   DM_DEPTH_DEF  : default number of 32-bit words (12 KiB)
//   DM_BASE_DEF   : default byte address of word 0
//   DM_LAT_W      : width of the latency down-counter
//   dm_merge()    : byte-enable merge of store data into an existing word
// ---------------------------------------------------------------------------
package dm_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dm_state_t;

  localparam int          DM_DEPTH_DEF = 3072;
  localparam logic [31:0] DM_BASE_DEF  = 32'h0000_0000;
  localparam int          DM_LAT_W     = 4;

  // Replace only the bytes whose enable bit is set; bit i covers bits 8i+7:8i.
  function automatic logic [31:0] dm_merge(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = old[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_sram_array.sv
// ---------------------------------------------------------------------------
// dm_sram_array -- single-port DEPTH x 32 data array.
//   clk   : write clock
//   clr   : full-word zero write to idx (takes priority over we)
//   we    : byte-enabled write of wdata to idx
//   idx   : word index shared by read, write and clear
//   be    : byte enables for we
//   wdata : store data
//   rdata : combinational read of word idx (0 when idx is beyond DEPTH)
// Indices at or beyond DEPTH are never written.
// ---------------------------------------------------------------------------
module dm_sram_array
  import dm_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);

  logic [31:0] mem [DEPTH];
  logic        in_range_s;

  assign in_range_s = ({1'b0, idx} < DEPTH_V);

  // Synchronous write port: clear sweep or byte-merged store.
  always_ff @(posedge clk) begin
    if (in_range_s) begin
      if (clr) begin
        mem[idx] <= 32'h0000_0000;
      end else if (we) begin
        mem[idx] <= dm_merge(mem[idx], wdata, be);
      end
    end
  end

  // Combinational read port.
  always_comb begin
    if (in_range_s) begin
      rdata = mem[idx];
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder -- data-memory target for the core's load/store path.
// Accepts one word-aligned load/store at a time over a valid/ready request
// channel, commits it LATENCY cycles after acceptance and returns data or a
// completion with an error flag. After every reset the whole array is
// zero-filled before the first request is accepted.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_be              : store byte enables
//   req_wdata           : store data
//   req_pc              : issuing PC, only used by the store trace
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data (0 for stores and errors)
//   rsp_err             : misaligned or out-of-range access
//
// Build option: DM_WRITE_TRACE_EN prints one line per successful store
// commit in the core's register-write trace format.
// ---------------------------------------------------------------------------
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH   = DM_DEPTH_DEF,
  parameter logic [31:0] BASE    = DM_BASE_DEF,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_CLEAR = CLEAR;
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;

  localparam bit                  LAT_ONE    = (LATENCY == 1);
  localparam logic [DM_LAT_W-1:0] LAT_LOAD   = DM_LAT_W'(LATENCY - 1);
  localparam logic [DM_LAT_W-1:0] LAT_LAST   = DM_LAT_W'(1);
  localparam logic [DM_LAT_W-1:0] LAT_ZERO   = DM_LAT_W'(0);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]    IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0]    IDX_ONE    = IDX_W'(1);
  localparam logic [31:0]         ADDR_LIMIT = 32'(4 * DEPTH);

  // Registered state
  logic [1:0]          state_r;
  logic [DM_LAT_W-1:0] lat_cnt_r;
  logic [IDX_W-1:0]    clr_idx_r;
  logic                we_r;
  logic [3:0]          be_r;
  logic [31:0]         wdata_r;
  logic [31:0]         addr_r;
  logic                req_ready_r;
  logic                rsp_valid_r;
  logic [31:0]         rsp_rdata_r;
  logic                rsp_err_r;

  // Next-state / datapath signals
  logic [1:0]          state_nx_s;
  logic [DM_LAT_W-1:0] lat_nx_s;
  logic [IDX_W-1:0]    clr_nx_s;
  logic                cap_s;
  logic                commit_s;
  logic                cur_we_s;
  logic [3:0]          cur_be_s;
  logic [31:0]         cur_wdata_s;
  logic [31:0]         cur_addr_s;
  logic [31:0]         off_s;
  logic                err_s;
  logic                arr_clr_s;
  logic                arr_we_s;
  logic [IDX_W-1:0]    arr_idx_s;
  logic [31:0]         arr_rdata_s;

  // FSM transitions, latency counter and clear-index sequencing.
  always_comb begin
    state_nx_s = state_r;
    lat_nx_s   = lat_cnt_r;
    clr_nx_s   = clr_idx_r;
    cap_s      = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        if (clr_idx_r == IDX_LAST) begin
          state_nx_s = ST_IDLE;
          clr_nx_s   = IDX_ZERO;
        end else begin
          clr_nx_s   = clr_idx_r + IDX_ONE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          cap_s = 1'b1;
          if (LAT_ONE) begin
            state_nx_s = ST_RESP;
          end else begin
            state_nx_s = ST_WAIT;
            lat_nx_s   = LAT_LOAD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          state_nx_s = ST_RESP;
          lat_nx_s   = LAT_ZERO;
        end else begin
          lat_nx_s   = lat_cnt_r - LAT_LAST;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: begin
        state_nx_s = ST_CLEAR;
        clr_nx_s   = IDX_ZERO;
      end
    endcase
  end

  // With LATENCY=1 the commit happens on the acceptance edge itself, so the
  // live request is used; otherwise the captured copy is.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_we_s    = req_we;
      cur_be_s    = req_be;
      cur_wdata_s = req_wdata;
      cur_addr_s  = req_addr;
    end else begin
      cur_we_s    = we_r;
      cur_be_s    = be_r;
      cur_wdata_s = wdata_r;
      cur_addr_s  = addr_r;
    end
  end

  // Error check and array control; the array is only touched by valid stores.
  always_comb begin
    off_s     = cur_addr_s - BASE;
    err_s     = (cur_addr_s[1:0] != 2'b00) || (off_s >= ADDR_LIMIT);
    commit_s  = (state_nx_s == ST_RESP) && (state_r != ST_RESP);
    arr_clr_s = (state_r == ST_CLEAR);
    arr_we_s  = commit_s && cur_we_s && !err_s;
    if (state_r == ST_CLEAR) begin
      arr_idx_s = clr_idx_r;
    end else begin
      arr_idx_s = off_s[IDX_W+1:2];
    end
  end

  dm_sram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .clr   (arr_clr_s),
    .we    (arr_we_s),
    .idx   (arr_idx_s),
    .be    (cur_be_s),
    .wdata (cur_wdata_s),
    .rdata (arr_rdata_s)
  );

  // State, latency counter and clear index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_CLEAR;
      lat_cnt_r <= LAT_ZERO;
      clr_idx_r <= IDX_ZERO;
    end else begin
      state_r   <= state_nx_s;
      lat_cnt_r <= lat_nx_s;
      clr_idx_r <= clr_nx_s;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r    <= 1'b0;
      be_r    <= 4'h0;
      wdata_r <= 32'h0000_0000;
      addr_r  <= 32'h0000_0000;
    end else if (cap_s) begin
      we_r    <= req_we;
      be_r    <= req_be;
      wdata_r <= req_wdata;
      addr_r  <= req_addr;
    end
  end

  // Registered handshake outputs follow the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      req_ready_r <= (state_nx_s == ST_IDLE);
      rsp_valid_r <= (state_nx_s == ST_RESP);
    end
  end

  // Response payload: loaded on the commit edge, held through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (commit_s) begin
      rsp_err_r <= err_s;
      if (err_s || cur_we_s) begin
        rsp_rdata_r <= 32'h0000_0000;
      end else begin
        rsp_rdata_r <= arr_rdata_s;
      end
    end else if (state_nx_s != ST_RESP) begin
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

`ifdef DM_WRITE_TRACE_EN
  logic [31:0] pc_r;
  logic [31:0] cur_pc_s;

  // PC capture for the trace line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= 32'h0000_0000;
    end else if (cap_s) begin
      pc_r <= req_pc;
    end
  end

  // PC follows the same live/captured selection as the rest of the request.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_pc_s = req_pc;
    end else begin
      cur_pc_s = pc_r;
    end
  end

  // One trace line per successful store commit.
  always_ff @(posedge clk) begin
    if (reset && arr_we_s) begin
      $display("%d@%h: *%h <= %h", $time, cur_pc_s, {cur_addr_s[31:2], 2'b00},
               dm_merge(arr_rdata_s, cur_wdata_s, cur_be_s));
    end
  end
`else
  logic unused_pc_s;
  assign unused_pc_s = ^req_pc;
`endif

endmodule
